// File: rtl/grid_tile_renderer.sv
// grid_tile_renderer: walks the raster, reads grid cells and emits palette, outline, blink or background pixels.
module grid_tile_renderer #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int CELL         = 24,
    parameter int GRID_COLS    = 12,
    parameter int GRID_ROWS    = 20,
    parameter int X0           = 176,
    parameter int Y0           = 0,
    parameter int RD_LAT       = 1,
    parameter int ADDR_W       = 8,
    parameter int BLINK_FRAMES = 16
) (
    input  logic              px_clk,
    input  logic              reset,
    input  logic              de,
    input  logic              frame_start,
    input  logic [7:0]        grid_data,
    input  logic              outline_en,
    input  logic [7:0]        bg_rgb,
    output logic [ADDR_W-1:0] grid_addr,
    output logic              grid_rd,
    output logic [7:0]        pixel_rgb,
    output logic              pixel_de
);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam int X1 = X0 + CELL * GRID_COLS;
    localparam int Y1 = Y0 + CELL * GRID_ROWS;
    localparam logic [4:0] CMAX = 5'(CELL - 1);
    localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);
    localparam logic [YW-1:0] YMAX = YW'(V_ACTIVE - 1);
    localparam logic [15:0][7:0] PAL = {{8{8'h00}}, 8'h00, 8'h1F, 8'hE3, 8'hFC,
                                        8'hEC, 8'h03, 8'hE0, 8'h1C, 8'hFF};

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [4:0]        x_off, y_off;
    logic [ADDR_W-1:0] col, row_base;
    logic [FW-1:0]     fcnt;
    logic              blink_phase, de_q, synced;
    logic [2:0]        pipe [RD_LAT];
    logic [2:0]        out_stage;
    logic [7:0]        pix_n;
    logic              in_grid, y_in, line_end, cell_edge, unused;
    int                xi, yi;

    always_comb begin
        xi        = int'(x);
        yi        = int'(y);
        y_in      = yi >= Y0 && yi < Y1;
        in_grid   = de && y_in && xi >= X0 && xi < X1;
        line_end  = de_q && !de && synced;
        cell_edge = x_off == '0 || y_off == '0;
        grid_rd   = in_grid;
        grid_addr = in_grid ? row_base + col : '0;
        out_stage = pipe[RD_LAT-1];
        // stage bits: [2] de, [1] in grid, [0] cell edge
        pix_n     = !out_stage[2] ? 8'h00 :
                    !out_stage[1] ? bg_rgb :
                    outline_en && out_stage[0] ? 8'h92 :
                    grid_data[7] && blink_phase ? 8'hFF : PAL[grid_data[3:0]];
        unused    = ^grid_data[6:4];
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            de_q        <= 1'b0;
            synced      <= 1'b0;
            x           <= '0;
            y           <= '0;
            x_off       <= '0;
            y_off       <= '0;
            col         <= '0;
            row_base    <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
            pixel_de    <= 1'b0;
            pixel_rgb   <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            de_q <= de;
            x    <= de ? x + XW'(1) : '0;
            if (frame_start) begin
                synced   <= 1'b1;
                y        <= '0;
                y_off    <= '0;
                row_base <= '0;
                fcnt     <= fcnt == FMAX ? '0 : fcnt + FW'(1);
                if (fcnt == FMAX) blink_phase <= ~blink_phase;
            end else if (line_end) begin
                if (y != YMAX) y <= y + YW'(1);
                if (y_in) begin
                    y_off <= y_off == CMAX ? '0 : y_off + 5'd1;
                    if (y_off == CMAX) row_base <= row_base + ADDR_W'(GRID_COLS);
                end
            end
            if (in_grid && !frame_start) begin
                x_off <= x_off == CMAX ? '0 : x_off + 5'd1;
                if (x_off == CMAX) col <= col + ADDR_W'(1);
            end else begin
                x_off <= '0;
                col   <= '0;
            end
            pipe[0] <= {de, in_grid, cell_edge};
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
            pixel_de  <= out_stage[2];
            pixel_rgb <= pix_n;
        end
    end
endmodule
